// File: rtl/mo_conv.sv
// Montgomery-domain converter: x*2^W mod Q (dir 0) or x*2^-W mod Q (dir 1), one bit per cycle.
// Result WIDTH cycles after accept (+1 with MO_CONV_PREREDUCE_EN); DONE holds the result until out_ready.
module mo_conv #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] QX = (WIDTH + 1)'(Q);

  typedef enum logic [1:0] {IDLE, PRE, CALC, DONE} state_t;

  state_t          state, nxt;
  logic [WIDTH:0]  acc;
  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  step;
  logic            dir_q;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef MO_CONV_PREREDUCE_EN
          nxt = PRE;
`else
          nxt = CALC;
`endif
        end
      end
`ifdef MO_CONV_PREREDUCE_EN
      PRE:  nxt = CALC;
`endif
      CALC: if (cnt == LAST) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // One step: doubling mod Q for dir 0, halving mod Q (add Q when odd) for dir 1.
  always_comb begin
    sum  = '0;
    step = '0;
    if (!dir_q) begin
      step = {acc[WIDTH-1:0], 1'b0};
      if (step >= QX) step = step - QX;
    end else begin
      sum  = acc + (acc[0] ? QX : '0);
      step = sum >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      dir_q    <= 1'b0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc   <= {1'b0, in_data};
            dir_q <= in_dir;
            cnt   <= '0;
          end
        end
`ifdef MO_CONV_PREREDUCE_EN
        PRE: begin
          if (acc >= QX) acc <= acc - QX;
        end
`endif
        CALC: begin
          acc <= step;
          if (cnt == LAST) begin
            out_data <= step[WIDTH-1:0];
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mo_conv.sv
// Directed and random checks of mo_conv (WIDTH=12, Q=3329) against a modular-arithmetic reference.
module tb_mo_conv;

`ifdef MO_CONV_PREREDUCE_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 12;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pops  = 0;
  bit en    = 0;
  bit rand_rdy = 0;

  typedef struct {int exp; int hs;} ent_t;
  ent_t q[$];

  mo_conv #(.WIDTH(12), .Q(3329)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model(input int x, input bit d);
    longint p;
    p = d ? 64'd2704 : 64'd4096;
    return int'((longint'(x) * p) % 64'd3329);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: reference results, latency, hold stability, ready/busy relation.
  initial begin
    bit hold = 0;
    int hold_dat = 0;
    bit vld_seen = 0;
    ent_t e;
    forever begin
      @(negedge clk);
      if (en) begin
        if (!rst_n) begin
          q.delete();
          vld_seen = 0;
          hold = 0;
        end else begin
          check("rdy_vs_busy", int'(in_ready), int'(!busy));
          if (hold) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), hold_dat);
          end
          if (out_valid && !vld_seen) begin
            vld_seen = 1;
            check("pending_result", q.size(), 1);
            if (q.size() > 0) check("latency", cyc - q[0].hs, LAT);
          end
          if (in_valid && in_ready) begin
            e.exp = model(int'(in_data), in_dir);
            e.hs  = cyc + 1;
            q.push_back(e);
          end
          if (out_valid && out_ready && q.size() > 0) begin
            check("model", int'(out_data), q[0].exp);
            void'(q.pop_front());
            pops++;
            vld_seen = 0;
          end
          hold     = out_valid && !out_ready;
          hold_dat = int'(out_data);
        end
      end
    end
  end

  task automatic do_conv(input int x, input bit d, output int res);
    bit hs;
    bit got;
    int n;
    hs = 0;
    got = 0;
    res = -1;
    in_valid = 1'b1;
    in_data  = x[11:0];
    in_dir   = d;
    n = 0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("accept", int'(hs), 1);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        res = int'(out_data);
        got = 1;
      end
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    end
    check("result_arrived", int'(got), 1);
  endtask

  initial begin
    int r;
    int y;
    int x;
    int seen;
    int pops0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1;
    out_ready = 1'b1;

    do_conv(1, 0, r);    check("to_mont_1", r, 767);
    do_conv(767, 1, r);  check("from_mont_767", r, 1);
    do_conv(1, 1, r);    check("from_mont_1", r, 2704);
    do_conv(3328, 0, r); check("to_mont_qm1", r, 2562);
    do_conv(0, 0, r);    check("to_mont_0", r, 0);
    do_conv(0, 1, r);    check("from_mont_0", r, 0);

    // Stall in DONE while a stray input is offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 12'd5; in_dir = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("stall_reached_done", seen, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = (k == 2);
      in_data  = 12'd100;
      @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), 506);
      check("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    pops0 = pops;
    @(posedge clk); #1;
    out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("stall_one_pop", pops - pops0, 1);
    check("stall_no_extra", seen, 0);
    check("stall_queue_empty", q.size(), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Reset in the middle of CALC.
    in_valid = 1'b1; in_data = 12'd7; in_dir = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_busy", int'(busy), 0);
    @(posedge clk); #1;
    do_conv(2, 0, r);    check("after_reset", r, 1534);

`ifdef MO_CONV_PREREDUCE_EN
    do_conv(3329, 0, r); check("prered_q", r, 0);
    do_conv(4095, 0, r); check("prered_max", r, 1618);
`endif

    rand_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      x = $urandom_range(0, 3328);
      do_conv(x, 0, y);
      check("rand_to", y, model(x, 0));
      do_conv(y, 1, r);
      check("roundtrip", r, x);
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mo_conv.md
Name: mo_conv

Overview:
- Iterative Montgomery-domain converter with valid/ready handshakes on both sides.
- Direction 0 (to-Montgomery): x -> x*2^WIDTH mod Q.
- Direction 1 (from-Montgomery): x -> x*2^-WIDTH mod Q.
- Sits in front of and behind the pipelined Montgomery multiplier. It moves coefficients into the domain that multiplier expects and back out. It uses one shared shift/add datapath, one bit per cycle.

Parameters:
- WIDTH, `DATA_WIDTH, coefficient width in bits.
- Q, `Q, modulus. Must be odd, with 2^(WIDTH-1) < Q < 2^WIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  input coefficient valid
- in_ready  out  1  converter can accept a coefficient
- in_data  in  WIDTH  coefficient, range 0..Q-1 (0..2^WIDTH-1 with optional feature)
- in_dir  in  1  0 = to-Montgomery, 1 = from-Montgomery; sampled with in_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  converted coefficient, range 0..Q-1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst_n sampled low at a clock edge forces state IDLE. Also forces in_ready=1, out_valid=0, out_data=0, busy=0, counter=0. Reset has priority over every other event, including reset mid-CALC; any in-flight result is discarded.
- Interface: clock clk; reset rst_n, synchronous, active-low.
- FSM states: IDLE, (PRE), CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into a WIDTH+1-bit accumulator and latch in_dir.
  - Clear counter; go to CALC (PRE if feature enabled).
- CALC, one step per cycle:
  - dir=0: t = acc<<1; if t >= Q then t = t-Q.
  - dir=1: if acc[0] then t = acc+Q; then t = t>>1.
  - Intermediates are WIDTH+1 bits; result always in 0..Q-1 given input in 0..Q-1.
  - Counter increments each step. After step WIDTH (counter == WIDTH-1), register the result into out_data and go to DONE.
- DONE:
  - out_valid=1; out_data held stable until out_ready.
  - On out_ready: out_valid falls next cycle and the FSM returns to IDLE.
- in_ready=0 in every state but IDLE. in_valid asserted outside IDLE is ignored, with no effect on the running operation.
- Latency: handshake at edge N, out_valid high after edge N+WIDTH (N+WIDTH+1 with feature). Throughput is one conversion per WIDTH+2 cycles minimum with out_ready held high.
- out_ready low in DONE: block stalls indefinitely; out_valid and out_data unchanged.
- out_ready high while not in DONE: no effect.
- Input 0 yields 0 in both directions. Q-1 maps correctly (no overflow, since 2(Q-1) < 2^(WIDTH+1)).
- Without the optional feature, in_data >= Q is outside the contract; output is deterministic but unspecified.

Optional Feature:
- Macro: MO_CONV_PREREDUCE_EN.
- Defined:
  - Adds state PRE, one cycle between IDLE and CALC: if acc >= Q then acc = acc-Q.
  - in_data then accepts the full range 0..2^WIDTH-1 (2^WIDTH < 2Q guarantees a single subtraction suffices).
  - Latency becomes WIDTH+1.
- Undefined: no PRE state; latency WIDTH; inputs must be < Q.

Test Plan:
- WIDTH=12, Q=3329, dir=0, in_data=1 -> out_data=767 after 12 cycles. Then dir=1, in_data=767 -> out_data=1.
- dir=1, in_data=1 -> out_data=2704. dir=0, in_data=3328 -> 2562. dir=0 and dir=1 with in_data=0 -> 0.
- out_ready held low 5 cycles in DONE, with in_valid pulsed meanwhile -> out_data/out_valid stable, in_ready=0. On release, exactly one result is consumed and the pulsed input is never taken.
- rst_n low for 1 cycle at CALC step 6 -> next cycle out_valid=0, in_ready=1, busy=0. A subsequent dir=0, in_data=2 -> 1534.
- MO_CONV_PREREDUCE_EN defined: dir=0, in_data=3329 -> 0; in_data=4095 -> 1618; latency 13 cycles.
- 200 random back-to-back conversions with random out_ready stalls:
  - each to/from round-trip equals the original;
  - each result equals the reference model x*4096 mod 3329 (dir=0) or x*2704 mod 3329 (dir=1).
